// File: rtl/nrx_hs_ram_arbiter.sv
// Work-RAM port arbiter between the Z80 core and the hiscore save/restore engine.
// Pauses the CPU, waits for halt plus a settle interval, then lends the RAM port to the engine.
module nrx_hs_ram_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic          hs_access,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_ready,
    output logic          hs_grant,
    output logic          hs_fail,

    output logic          pause_req,
    input  logic          cpu_halted,

    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dout,
    output logic [DW-1:0] cpu_din,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSING,
        ST_SETTLE,
        ST_OWNED,
        ST_RELEASE
    } state_t;

    localparam logic [11:0] WAIT_LAST   = 12'(TIMEOUT - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

    state_t        state;
    state_t        next_state;
    logic          fail_now;
    logic          owner;
    logic          owner_d;
    logic [11:0]   wait_cnt;
    logic [3:0]    settle_cnt;
    logic [AW-1:0] prev_addr;
    logic          rd_req;
    logic          rd_pend;
    logic          wr_ack;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        fail_now   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs_access) next_state = ST_PAUSING;
            end
            ST_PAUSING: begin
                if (!hs_access) begin
                    next_state = ST_IDLE;
                end else if (cpu_halted) begin
                    next_state = ST_SETTLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ST_IDLE;
                    fail_now   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!hs_access)                     next_state = ST_RELEASE;
                else if (settle_cnt == SETTLE_LAST) next_state = ST_OWNED;
            end
            ST_OWNED: begin
                if (!hs_access) next_state = ST_RELEASE;
            end
            ST_RELEASE: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // A read is issued on the first owned cycle and on every engine address change.
    assign rd_req = owner && !hs_write && (!owner_d || (hs_address != prev_addr));
    assign wr_ack = owner && hs_write;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= ST_IDLE;
            pause_req   <= 1'b0;
            hs_grant    <= 1'b0;
            hs_fail     <= 1'b0;
            hs_ready    <= 1'b0;
            hs_data_out <= '0;
            owner       <= 1'b0;
            owner_d     <= 1'b0;
            wait_cnt    <= '0;
            settle_cnt  <= '0;
            prev_addr   <= '0;
            rd_pend     <= 1'b0;
        end else begin
            state      <= next_state;
            pause_req  <= (next_state != ST_IDLE);
            hs_grant   <= (next_state == ST_OWNED);
            owner      <= (next_state == ST_OWNED);
            owner_d    <= owner;
            hs_fail    <= fail_now;
            wait_cnt   <= (state == ST_PAUSING) ? wait_cnt + 12'd1 : 12'd0;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 4'd1 : 4'd0;
            prev_addr  <= hs_address;
            rd_pend    <= rd_req;
            hs_ready   <= wr_ack || rd_pend;
            if (rd_pend) hs_data_out <= ram_rdata;
        end
    end

    // The port mux follows the registered owner flag, so a write in a reset cycle still lands.
    assign ram_addr  = owner ? hs_address : cpu_addr;
    assign ram_wdata = owner ? hs_data_in : cpu_dout;
    assign ram_we    = owner ? hs_write   : (cpu_cs & cpu_we);
    assign cpu_din   = ram_rdata;

endmodule

// File: tb/tb_nrx_hs_ram_arbiter.sv
// Directed bench for nrx_hs_ram_arbiter: grant timing, engine read/write, timeout, release, reset.
// Engine transfers are scored against a queue of expected hs_ready events.
module tb_nrx_hs_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          hs_access;
    logic [AW-1:0] hs_address;
    logic [DW-1:0] hs_data_in;
    logic          hs_write;
    logic [DW-1:0] hs_data_out;
    logic          hs_ready;
    logic          hs_grant;
    logic          hs_fail;
    logic          pause_req;
    logic          cpu_halted;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_din;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    always #5 clk_sys = ~clk_sys;

    nrx_hs_ram_arbiter #(
        .AW(AW), .DW(DW), .SETTLE(2), .TIMEOUT(16)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .hs_access(hs_access), .hs_address(hs_address), .hs_data_in(hs_data_in),
        .hs_write(hs_write), .hs_data_out(hs_data_out), .hs_ready(hs_ready),
        .hs_grant(hs_grant), .hs_fail(hs_fail), .pause_req(pause_req),
        .cpu_halted(cpu_halted), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    // Work RAM: synchronous read, one cycle of latency, read-before-write.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit            is_read;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input bit is_read, input logic [DW-1:0] data);
        exp_t e;
        e.is_read = is_read;
        e.data    = data;
        sb.push_back(e);
    endtask

    // Every hs_ready pulse must match the oldest outstanding engine transfer.
    always @(negedge clk_sys) begin : ready_monitor
        exp_t e;
        if (hs_ready) begin
            check("ready_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.is_read) check("sb_read_data", 32'(hs_data_out), 32'(e.data));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  waited;
        bit  grant_seen;

        reset      = 1'b1;
        hs_access  = 1'b0;
        hs_address = '0;
        hs_data_in = '0;
        hs_write   = 1'b0;
        cpu_halted = 1'b1;
        cpu_cs     = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 16'h1234;
        cpu_dout   = '0;

        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_pause_req", 32'(pause_req), 32'd0);
        check("rst_grant", 32'(hs_grant), 32'd0);
        check("rst_ready", 32'(hs_ready), 32'd0);
        check("rst_fail", 32'(hs_fail), 32'd0);
        check("rst_data_out", 32'(hs_data_out), 32'd0);
        check("rst_ram_addr_cpu", 32'(ram_addr), 32'h1234);

        // CPU preloads RAM through the idle port
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8040; cpu_dout = 8'h11;
        #1;
        check("cpu_wr_we", 32'(ram_we), 32'd1);
        check("cpu_wr_data", 32'(ram_wdata), 32'h11);
        step();
        cpu_addr = 16'h8041; cpu_dout = 8'hC3;
        step();
        cpu_we = 1'b0;
        step();
        check("cpu_din_read", 32'(cpu_din), 32'hC3);
        cpu_cs = 1'b0; cpu_addr = 16'h0100;

        // Engine write while not owning the port is ignored
        hs_write = 1'b1; hs_address = 16'h8040; hs_data_in = 8'hFF;
        #1;
        check("ignored_we", 32'(ram_we), 32'd0);
        step();
        hs_write = 1'b0;
        check("ignored_ready", 32'(hs_ready), 32'd0);

        // Basic grant: access at N -> pause_req at N+1 -> grant at N+4
        hs_access = 1'b1; hs_address = 16'h8040;
        step();
        check("grant_pause_n1", 32'(pause_req), 32'd1);
        check("grant_low_n1", 32'(hs_grant), 32'd0);
        step();
        check("grant_low_n2", 32'(hs_grant), 32'd0);
        step();
        check("grant_low_n3", 32'(hs_grant), 32'd0);
        step();
        check("grant_high_n4", 32'(hs_grant), 32'd1);
        check("grant_ram_addr", 32'(ram_addr), 32'h8040);
        push(1'b1, 8'h11);
        cpu_halted = 1'b0;
        step();
        check("first_read_ready_early", 32'(hs_ready), 32'd0);
        step();
        check("first_read_ready", 32'(hs_ready), 32'd1);
        check("first_read_data", 32'(hs_data_out), 32'h11);
        check("grant_kept_halt_drop", 32'(hs_grant), 32'd1);
        cpu_halted = 1'b1;

        // Engine write with a competing CPU write in the same cycle
        hs_write = 1'b1; hs_data_in = 8'h5A;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_dout = 8'hEE;
        #1;
        check("hs_wr_we", 32'(ram_we), 32'd1);
        check("hs_wr_addr", 32'(ram_addr), 32'h8040);
        check("hs_wr_data", 32'(ram_wdata), 32'h5A);
        push(1'b0, 8'h00);
        step();
        hs_write = 1'b0;
        check("hs_wr_ready", 32'(hs_ready), 32'd1);
        #1;
        check("cpu_wr_blocked", 32'(ram_we), 32'd0);
        cpu_cs = 1'b0; cpu_we = 1'b0;
        step();
        check("hs_wr_ready_single", 32'(hs_ready), 32'd0);

        // Engine read: address change -> data two cycles later
        hs_address = 16'h8041;
        push(1'b1, 8'hC3);
        step();
        check("rd_ready_k1", 32'(hs_ready), 32'd0);
        step();
        check("rd_ready_k2", 32'(hs_ready), 32'd1);
        check("rd_data_k2", 32'(hs_data_out), 32'hC3);
        hs_address = 16'h8040;
        push(1'b1, 8'h5A);
        step();
        step();
        check("rd_back_ready", 32'(hs_ready), 32'd1);
        check("rd_back_data", 32'(hs_data_out), 32'h5A);

        // Release, then re-request immediately from RELEASE
        hs_access = 1'b0;
        step();
        check("rel_grant", 32'(hs_grant), 32'd0);
        check("rel_pause_held", 32'(pause_req), 32'd1);
        cpu_addr = 16'h8000;
        #1;
        check("rel_ram_addr_cpu", 32'(ram_addr), 32'h8000);
        hs_access = 1'b1;
        step();
        check("rel_pause_gap", 32'(pause_req), 32'd0);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_dout = 8'h77;
        #1;
        check("idle_cpu_we", 32'(ram_we), 32'd1);
        check("idle_cpu_wdata", 32'(ram_wdata), 32'h77);
        step();
        cpu_cs = 1'b0; cpu_we = 1'b0;
        check("rereq_pause", 32'(pause_req), 32'd1);
        check("rereq_grant_low", 32'(hs_grant), 32'd0);
        step();
        step();
        check("rereq_grant_low2", 32'(hs_grant), 32'd0);
        hs_address = 16'h8000;
        step();
        check("rereq_grant", 32'(hs_grant), 32'd1);
        push(1'b1, 8'h77);
        step();
        step();
        check("rereq_read_data", 32'(hs_data_out), 32'h77);

        // Reset while owned: the reset-cycle write still reaches RAM
        reset = 1'b1;
        hs_write = 1'b1; hs_address = 16'h8002; hs_data_in = 8'h99;
        #1;
        check("rst_owned_we", 32'(ram_we), 32'd1);
        check("rst_owned_addr", 32'(ram_addr), 32'h8002);
        step();
        reset = 1'b0; hs_write = 1'b0; hs_access = 1'b0;
        check("rst_owned_grant", 32'(hs_grant), 32'd0);
        check("rst_owned_pause", 32'(pause_req), 32'd0);
        check("rst_owned_ready", 32'(hs_ready), 32'd0);
        check("rst_owned_mem", 32'(mem[16'h8002]), 32'h99);
        cpu_addr = 16'h0456;
        #1;
        check("rst_owned_cpu_addr", 32'(ram_addr), 32'h0456);

        // Access dropped while pausing: back to idle without a fail pulse
        cpu_halted = 1'b0;
        hs_access = 1'b1;
        step();
        step();
        check("abort_pause", 32'(pause_req), 32'd1);
        hs_access = 1'b0;
        step();
        check("abort_pause_low", 32'(pause_req), 32'd0);
        check("abort_no_fail", 32'(hs_fail), 32'd0);
        step();
        check("abort_no_fail2", 32'(hs_fail), 32'd0);

        // Halt timeout: counter reaches 16 -> fail pulse on IDLE re-entry
        hs_access  = 1'b1;
        waited     = 0;
        grant_seen = 1'b0;
        while (!hs_fail && waited < 40) begin
            step();
            waited++;
            if (hs_grant) grant_seen = 1'b1;
        end
        check("timeout_fail_seen", 32'(hs_fail), 32'd1);
        check("timeout_cycle", 32'(waited), 32'd17);
        check("timeout_pause_low", 32'(pause_req), 32'd0);
        check("timeout_no_grant", 32'(grant_seen), 32'd0);
        hs_access = 1'b0;
        step();
        check("timeout_fail_single", 32'(hs_fail), 32'd0);

        step();
        step();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
